line_fill_engine: RTL and testbench
===================================

// Module: line_fill_engine
// PURPOSE
//  Parametrised memory-side engine between the cache controller and main_memory.
//  - Fetches a full cacheline word-by-word over the memory read handshake.
//  - Assembles the words and returns the line in one transfer.
//  - Also issues single-word write-through stores.
//  - Generalises the fixed 32b/8-word/one-word-at-a-time fill path so the team can
//    sweep line size, word width and memory latency.
// PARAMETERS
//  ADDR_W      32  byte address width
//  WORD_W      32  data word width (bits); multiple of 8
//  LINE_WORDS  8   words per cacheline; power of two, >=2
//  TIMEOUT     64  max WAIT cycles per word before fill_err; 0 disables the watchdog
// PORTS
//  clk                  in   1                  clock, rising edge
//  rst                  in   1                  async reset, active-high
//  fill_req_valid       in   1                  line fill request
//  fill_req_ready       out  1                  fill accepted when valid&&ready
//  fill_req_addr        in   ADDR_W             miss byte address (word offset = critical word)
//  wt_req_valid         in   1                  write-through request
//  wt_req_ready         out  1                  write accepted when valid&&ready
//  wt_req_addr          in   ADDR_W             store byte address
//  wt_req_data          in   WORD_W             store data
//  fill_done            out  1                  1-cycle pulse: fill_line/fill_addr valid
//  fill_err             out  1                  1-cycle pulse (with fill_done): watchdog expired
//  fill_addr            out  ADDR_W             line-aligned address of returned line
//  fill_line            out  LINE_WORDS*WORD_W  word i at bits [i*WORD_W +: WORD_W]
//  fill_crit_valid      out  1                  1-cycle pulse: critical word available
//  fill_crit_data       out  WORD_W             critical word data
//  busy                 out  1                  state != IDLE
//  mem_addr             out  ADDR_W             memory read/write address
//  mem_write_en         out  1                  memory write strobe
//  mem_write_data       out  WORD_W             memory write data
//  mem_read_addr_valid  out  1                  read address strobe (1 cycle per word)
//  mem_read_ready       out  1                  engine can accept read data
//  mem_read_valid       in   1                  read data valid
//  mem_read_data        in   WORD_W             read data
// BEHAVIOUR
//  - Clock and reset: one clock, clk. Reset rst is asynchronous, active-high. All outputs and
//    registers clear to 0 on reset; state goes to IDLE.
//  - Reset mid-fill: the fill is aborted and no fill_done is issued.
//  - States: IDLE, WRITE, REQ, WAIT, DONE.
//  - IDLE: wt_req_ready=1. fill_req_ready = !wt_req_valid, so a write wins over a simultaneous
//    fill and the fill then reads the new data.
//      - wt accept -> WRITE.
//      - fill accept -> REQ. The address is latched; word counter cnt=0; start word s is set.
//  - WRITE, 1 cycle: mem_write_en=1, mem_addr=latched wt_req_addr, mem_write_data=latched data.
//    Next state IDLE.
//  - REQ, 1 cycle: mem_read_addr_valid=1, mem_addr = line base + ((s+cnt) mod LINE_WORDS)*WORD_W/8.
//    Next state WAIT.
//  - WAIT: mem_read_ready=1 and mem_addr is held.
//      - On mem_read_valid: store the data into word (s+cnt) mod LINE_WORDS and increment cnt.
//        If cnt was LINE_WORDS-1 -> DONE, else -> REQ.
//      - A read_valid in the same cycle it is first seen is accepted (zero extra latency).
//      - mem_read_valid outside WAIT is ignored.
//  - Watchdog: the WAIT cycle counter resets in each REQ. If it reaches TIMEOUT -> DONE with
//    fill_err=1; unfilled words are 0.
//  - DONE, 1 cycle: fill_done=1; fill_line and fill_addr are valid. Next state IDLE.
//    fill_line holds its value until the next fill starts.
//  - Latency: with memory latency L (REQ to read_valid, L>=1), one fill takes
//    LINE_WORDS*(1+L)+1 cycles from accept to fill_done.
//  - Address arithmetic:
//      - offset width = $clog2(LINE_WORDS) + $clog2(WORD_W/8); line base = address with the
//        offset bits zeroed.
//      - word index wraps modulo LINE_WORDS; no carry into the tag/index bits.
// CONFIGURATION
//  - Macro LFE_CRITICAL_WORD_FIRST_EN defined:
//      - s = word offset of fill_req_addr.
//      - fill_crit_valid pulses in the cycle the first word (cnt==0) is captured;
//        fill_crit_data = that word.
//  - Macro undefined:
//      - s = 0 (sequential order).
//      - fill_crit_valid is tied to 0; fill_crit_data is tied to 0.
// STRUCTURE
//  - Package bdi_mem_pkg:
//      - lfe_state_e enum.
//      - function word_off_w(LINE_WORDS).
//      - function line_base(addr).
//  - Sub-module line_assembler: a LINE_WORDS x WORD_W register file.
//      - Indexed write port and clear-on-start.
//      - Output is the packed line.
//  - Everything else (FSM, counters, watchdog) lives in this file.
// TESTING
//  1. Reset then idle: all outputs 0, busy=0, fill_req_ready=1.
//  2. Fill 0x0000_1014, L=3, macro off: words 0..7 read from 0x1000..0x101C in order;
//     fill_done after 8*4+1=33 cycles; fill_addr=0x1000.
//  3. Same request, macro on: reads start at 0x1014 and wrap 0x1018, 0x101C, 0x1000, ...;
//     fill_crit_data=mem[0x1014]; fill_line identical to test 2.
//  4. wt(0x1004, 0xDEADBEEF) and fill(0x1000) asserted in the same cycle: write goes first;
//     fill_line word1 = 0xDEADBEEF.
//  5. Memory never returns mem_read_valid, TIMEOUT=64: fill_done and fill_err pulse
//     66 cycles after accept; the next request is accepted.
//  6. rst asserted during WAIT of word 3: state IDLE, no fill_done; a new fill completes normally.

Source files
------------

// File: rtl/bdi_mem_pkg.sv
// ============================================================================
// Module  : bdi_mem_pkg
// Purpose : Shared types and address helpers for the line fill engine.
//           - lfe_state_e : engine state encoding
//           - word_off_w  : number of word-index bits in a cacheline
//           - line_base   : zero the line-offset bits of a byte address
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package bdi_mem_pkg;

  typedef enum logic [2:0] {
    LFE_IDLE  = 3'd0,
    LFE_WRITE = 3'd1,
    LFE_REQ   = 3'd2,
    LFE_WAIT  = 3'd3,
    LFE_DONE  = 3'd4
  } lfe_state_e;

  // Widest address the helpers operate on; callers truncate to their width.
  localparam int LFE_MAX_ADDR_W = 64;

  function automatic int word_off_w(input int line_words);
    return $clog2(line_words);
  endfunction

  // off_w is the total line-offset width (word index bits + byte bits).
  function automatic logic [LFE_MAX_ADDR_W-1:0] line_base(
    input logic [LFE_MAX_ADDR_W-1:0] addr,
    input int                        off_w
  );
    return addr & ~((64'd1 << off_w) - 64'd1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/line_assembler.sv
// ============================================================================
// Module  : line_assembler
// Purpose : LINE_WORDS x WORD_W register file that collects a cacheline one
//           word at a time and presents it as a single packed vector.
// Ports   : clk, rst     - clock / async active-high reset
//           clear        - zero every word (start of a new fill)
//           wr_en        - write wr_data into word wr_idx
//           wr_idx       - word index to write
//           wr_data      - word data
//           line         - packed line, word i at [i*WORD_W +: WORD_W]
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module line_assembler
  import bdi_mem_pkg::*;
#(
  parameter int WORD_W     = 32,
  parameter int LINE_WORDS = 8,
  parameter int IDX_W      = word_off_w(LINE_WORDS)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear,
  input  logic                         wr_en,
  input  logic [IDX_W-1:0]             wr_idx,
  input  logic [WORD_W-1:0]            wr_data,
  output logic [LINE_WORDS*WORD_W-1:0] line
);

  logic [WORD_W-1:0] words [LINE_WORDS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LINE_WORDS; i++) words[i] <= '0;
    end else if (clear) begin
      // Words that never arrive (watchdog expiry) must read back as zero.
      for (int i = 0; i < LINE_WORDS; i++) words[i] <= '0;
    end else if (wr_en) begin
      words[wr_idx] <= wr_data;
    end
  end

  generate
    for (genvar g = 0; g < LINE_WORDS; g++) begin : g_pack
      assign line[g*WORD_W +: WORD_W] = words[g];
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/line_fill_engine.sv
// ============================================================================
// Module  : line_fill_engine
// Purpose : Memory-side engine between the cache controller and main memory.
//           Fetches a full cacheline word by word over the read handshake,
//           returns it in one transfer, and issues single-word write-through
//           stores. Writes win over a simultaneous fill.
// Config  : LFE_CRITICAL_WORD_FIRST_EN - when defined the fill starts at the
//           missing word and pulses fill_crit_valid when it arrives; when
//           undefined lines are fetched from word 0 and the crit outputs are 0.
// Ports   : fill_req_*  - line fill request (valid/ready, byte address)
//           wt_req_*    - write-through request (valid/ready, address, data)
//           fill_done/fill_err/fill_addr/fill_line - line return (1-cycle)
//           fill_crit_valid/fill_crit_data        - critical word early return
//           busy        - engine not idle
//           mem_*       - main memory read/write interface
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module line_fill_engine
  import bdi_mem_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int WORD_W     = 32,
  parameter int LINE_WORDS = 8,
  parameter int TIMEOUT    = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         fill_req_valid,
  output logic                         fill_req_ready,
  input  logic [ADDR_W-1:0]            fill_req_addr,
  input  logic                         wt_req_valid,
  output logic                         wt_req_ready,
  input  logic [ADDR_W-1:0]            wt_req_addr,
  input  logic [WORD_W-1:0]            wt_req_data,
  output logic                         fill_done,
  output logic                         fill_err,
  output logic [ADDR_W-1:0]            fill_addr,
  output logic [LINE_WORDS*WORD_W-1:0] fill_line,
  output logic                         fill_crit_valid,
  output logic [WORD_W-1:0]            fill_crit_data,
  output logic                         busy,
  output logic [ADDR_W-1:0]            mem_addr,
  output logic                         mem_write_en,
  output logic [WORD_W-1:0]            mem_write_data,
  output logic                         mem_read_addr_valid,
  output logic                         mem_read_ready,
  input  logic                         mem_read_valid,
  input  logic [WORD_W-1:0]            mem_read_data
);

  localparam int IDX_W  = word_off_w(LINE_WORDS);
  localparam int BYTE_W = $clog2(WORD_W/8);
  localparam int OFF_W  = IDX_W + BYTE_W;
  localparam logic [ADDR_W-1:0] BASE_MASK =
    ADDR_W'(line_base({LFE_MAX_ADDR_W{1'b1}}, OFF_W));
  localparam logic [IDX_W-1:0] LAST_CNT = IDX_W'(LINE_WORDS-1);

  lfe_state_e state, state_nxt;

  logic [ADDR_W-1:0] base_q;    // line base of the current fill
  logic [ADDR_W-1:0] wt_addr_q;
  logic [WORD_W-1:0] wt_data_q;
  logic [IDX_W-1:0]  start_q;   // word fetched first
  logic [IDX_W-1:0]  cnt_q;     // words captured so far
  logic              err_q;

  logic              wt_acc, fill_acc, cap_en, wdog_expire;
  logic [IDX_W-1:0]  start_idx, cur_idx;
  logic [ADDR_W-1:0] rd_addr;

`ifdef LFE_CRITICAL_WORD_FIRST_EN
  assign start_idx = fill_req_addr[BYTE_W +: IDX_W];
`else
  assign start_idx = '0;
`endif

  // Index arithmetic wraps inside the line; base has its offset bits clear,
  // so OR-ing the word offset can never carry into tag/index bits.
  assign cur_idx = start_q + cnt_q;
  assign rd_addr = base_q | (ADDR_W'(cur_idx) << BYTE_W);

  // Watchdog: counts WAIT cycles of the current word, restarted by each REQ.
  generate
    if (TIMEOUT > 0) begin : g_wdog
      localparam int WD_W = $clog2(TIMEOUT+1);
      logic [WD_W-1:0] wd_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst)                    wd_q <= '0;
        else if (state == LFE_REQ)  wd_q <= '0;
        else if (state == LFE_WAIT) wd_q <= wd_q + WD_W'(1);
      end
      assign wdog_expire = (state == LFE_WAIT) && (wd_q == WD_W'(TIMEOUT-1));
    end else begin : g_no_wdog
      assign wdog_expire = 1'b0;
    end
  endgenerate

  always_comb begin
    state_nxt           = state;
    fill_req_ready      = 1'b0;
    wt_req_ready        = 1'b0;
    wt_acc              = 1'b0;
    fill_acc            = 1'b0;
    cap_en              = 1'b0;
    fill_done           = 1'b0;
    fill_err            = 1'b0;
    busy                = (state != LFE_IDLE);
    mem_addr            = '0;
    mem_write_en        = 1'b0;
    mem_write_data      = '0;
    mem_read_addr_valid = 1'b0;
    mem_read_ready      = 1'b0;
    case (state)
      LFE_IDLE: begin
        wt_req_ready   = 1'b1;
        fill_req_ready = !wt_req_valid;
        if (wt_req_valid) begin
          wt_acc    = 1'b1;
          state_nxt = LFE_WRITE;
        end else if (fill_req_valid) begin
          fill_acc  = 1'b1;
          state_nxt = LFE_REQ;
        end
      end
      LFE_WRITE: begin
        mem_write_en   = 1'b1;
        mem_addr       = wt_addr_q;
        mem_write_data = wt_data_q;
        state_nxt      = LFE_IDLE;
      end
      LFE_REQ: begin
        mem_read_addr_valid = 1'b1;
        mem_addr            = rd_addr;
        state_nxt           = LFE_WAIT;
      end
      LFE_WAIT: begin
        mem_read_ready = 1'b1;
        mem_addr       = rd_addr;
        // Data arriving on the expiry cycle still counts.
        if (mem_read_valid) begin
          cap_en    = 1'b1;
          state_nxt = (cnt_q == LAST_CNT) ? LFE_DONE : LFE_REQ;
        end else if (wdog_expire) begin
          state_nxt = LFE_DONE;
        end
      end
      LFE_DONE: begin
        fill_done = 1'b1;
        fill_err  = err_q;
        state_nxt = LFE_IDLE;
      end
      default: state_nxt = LFE_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= LFE_IDLE;
      base_q    <= '0;
      wt_addr_q <= '0;
      wt_data_q <= '0;
      start_q   <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (wt_acc) begin
        wt_addr_q <= wt_req_addr;
        wt_data_q <= wt_req_data;
      end
      if (fill_acc) begin
        base_q  <= fill_req_addr & BASE_MASK;
        start_q <= start_idx;
        cnt_q   <= '0;
        err_q   <= 1'b0;
      end
      if (cap_en) cnt_q <= cnt_q + IDX_W'(1);
      if ((state == LFE_WAIT) && !mem_read_valid && wdog_expire) err_q <= 1'b1;
    end
  end

  assign fill_addr = base_q;

`ifdef LFE_CRITICAL_WORD_FIRST_EN
  assign fill_crit_valid = cap_en && (cnt_q == '0);
  assign fill_crit_data  = fill_crit_valid ? mem_read_data : '0;
`else
  assign fill_crit_valid = 1'b0;
  assign fill_crit_data  = '0;
`endif

  line_assembler #(
    .WORD_W     (WORD_W),
    .LINE_WORDS (LINE_WORDS),
    .IDX_W      (IDX_W)
  ) u_asm (
    .clk     (clk),
    .rst     (rst),
    .clear   (fill_acc),
    .wr_en   (cap_en),
    .wr_idx  (cur_idx),
    .wr_data (mem_read_data),
    .line    (fill_line)
  );

endmodule

`default_nettype wire

// File: tb/tb_line_fill_engine.sv
// ============================================================================
// Module  : tb_line_fill_engine
// Purpose : Self-checking bench for line_fill_engine (default parameters).
//           A behavioural memory answers reads after a per-fill latency;
//           a reference memory predicts every write, read address, returned
//           line, critical word and fill_done cycle into scoreboard queues
//           that a separate monitor drains. Honours LFE_CRITICAL_WORD_FIRST_EN.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_line_fill_engine;

  localparam int AW = 32, WW = 32, LW = 8, TO = 64;

  logic            clk = 1'b0;
  logic            rst;
  logic            fill_req_valid, fill_req_ready;
  logic [AW-1:0]   fill_req_addr;
  logic            wt_req_valid, wt_req_ready;
  logic [AW-1:0]   wt_req_addr;
  logic [WW-1:0]   wt_req_data;
  logic            fill_done, fill_err;
  logic [AW-1:0]   fill_addr;
  logic [LW*WW-1:0] fill_line;
  logic            fill_crit_valid;
  logic [WW-1:0]   fill_crit_data;
  logic            busy;
  logic [AW-1:0]   mem_addr;
  logic            mem_write_en;
  logic [WW-1:0]   mem_write_data;
  logic            mem_read_addr_valid, mem_read_ready;
  logic            mem_read_valid;
  logic [WW-1:0]   mem_read_data;

  line_fill_engine #(.ADDR_W(AW), .WORD_W(WW), .LINE_WORDS(LW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .fill_req_valid(fill_req_valid), .fill_req_ready(fill_req_ready), .fill_req_addr(fill_req_addr),
    .wt_req_valid(wt_req_valid), .wt_req_ready(wt_req_ready),
    .wt_req_addr(wt_req_addr), .wt_req_data(wt_req_data),
    .fill_done(fill_done), .fill_err(fill_err), .fill_addr(fill_addr), .fill_line(fill_line),
    .fill_crit_valid(fill_crit_valid), .fill_crit_data(fill_crit_data), .busy(busy),
    .mem_addr(mem_addr), .mem_write_en(mem_write_en), .mem_write_data(mem_write_data),
    .mem_read_addr_valid(mem_read_addr_valid), .mem_read_ready(mem_read_ready),
    .mem_read_valid(mem_read_valid), .mem_read_data(mem_read_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0, checks = 0;

  task automatic chk(input string name, input logic [LW*WW-1:0] act, input logic [LW*WW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_event(input string name);
    checks++;
    errors++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // ---------------- memory: actual contents and reference prediction -------
  logic [WW-1:0] ram     [int unsigned];
  logic [WW-1:0] ref_mem [int unsigned];

  function automatic logic [WW-1:0] peek(input logic [AW-1:0] a);
    int unsigned k;
    logic [WW-1:0] v;
    k = a & ~32'h3;
    if (!ref_mem.exists(k)) begin
      v = $urandom;
      ref_mem[k] = v;
      ram[k]     = v;
    end
    return ref_mem[k];
  endfunction

  function automatic logic [WW-1:0] ram_rd(input logic [AW-1:0] a);
    void'(peek(a));
    return ram[a & ~32'h3];
  endfunction

  int            lat  = 3;
  bit            mute = 1'b0;
  bit            pend = 1'b0;
  int            cd   = 0;
  logic [AW-1:0] rd_a = '0;

  // Read responder: data appears lat cycles after the address strobe cycle.
  always @(negedge clk) begin
    mem_read_valid = 1'b0;
    mem_read_data  = '0;
    if (rst) begin
      pend = 1'b0;
    end else begin
      if (pend) begin
        cd--;
        if (cd == 0) begin
          mem_read_valid = 1'b1;
          mem_read_data  = ram_rd(rd_a);
          pend           = 1'b0;
        end
      end
      if (mem_read_addr_valid && !mute) begin
        pend = 1'b1;
        cd   = lat;
        rd_a = mem_addr;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && mem_write_en) begin
      void'(peek(mem_addr));
      ram[mem_addr & ~32'h3] = mem_write_data;
    end
  end

  // ---------------- scoreboard -------------------------------------------
  typedef struct {
    logic [AW-1:0]    base;
    logic [LW*WW-1:0] line;
    logic             err;
    int               done_cyc;
  } fill_exp_t;

  fill_exp_t     fill_q[$];
  logic [AW-1:0] rd_q[$];
  logic [63:0]   wt_q[$];
  logic [WW-1:0] crit_q[$];
  fill_exp_t     mon_e;
  logic [63:0]   mon_w;
  int            rd_seen = 0;

  always begin
    @(negedge clk);
    #2;
    if (!rst) begin
      if (mem_read_addr_valid) begin
        rd_seen++;
        if (rd_q.size() == 0) fail_event("unexpected_read_request");
        else chk("read_addr", mem_addr, rd_q.pop_front());
      end
      if (mem_write_en) begin
        if (wt_q.size() == 0) fail_event("unexpected_write");
        else begin
          mon_w = wt_q.pop_front();
          chk("write_addr", mem_addr, mon_w[63:32]);
          chk("write_data", mem_write_data, mon_w[31:0]);
        end
      end
      if (fill_done) begin
        if (fill_q.size() == 0) fail_event("unexpected_fill_done");
        else begin
          mon_e = fill_q.pop_front();
          chk("fill_addr", fill_addr, mon_e.base);
          chk("fill_line", fill_line, mon_e.line);
          chk("fill_err", fill_err, mon_e.err);
          chk("fill_done_cycle", cyc, mon_e.done_cyc);
`ifndef LFE_CRITICAL_WORD_FIRST_EN
          chk("crit_data_tied", fill_crit_data, '0);
`endif
        end
      end
      if (fill_crit_valid) begin
`ifdef LFE_CRITICAL_WORD_FIRST_EN
        if (crit_q.size() == 0) fail_event("unexpected_crit_valid");
        else chk("crit_data", fill_crit_data, crit_q.pop_front());
`else
        fail_event("crit_valid_when_disabled");
`endif
      end
    end
  end

  // ---------------- reference prediction ---------------------------------
  task automatic predict_fill(input logic [AW-1:0] fa, input int L, input bit mt,
                              input bit abort, input int acc);
    fill_exp_t     e;
    logic [AW-1:0] base;
    int            s, nrd;
    base = fa & ~32'h1F;
`ifdef LFE_CRITICAL_WORD_FIRST_EN
    s = int'(fa[4:2]);
`else
    s = 0;
`endif
    nrd = mt ? 1 : (abort ? 4 : LW);
    for (int c = 0; c < nrd; c++) rd_q.push_back(base + AW'(((s + c) % LW) * 4));
`ifdef LFE_CRITICAL_WORD_FIRST_EN
    if (!mt) crit_q.push_back(peek(base + AW'(s * 4)));
`endif
    if (!abort) begin
      e.base = base;
      e.line = '0;
      for (int i = 0; i < LW; i++) e.line[i*WW +: WW] = mt ? '0 : peek(base + AW'(i * 4));
      e.err  = mt;
      // Edges from accept to the fill_done cycle (the done cycle itself is
      // the (n+1)-th cycle: 33 for L=3, 66 for a full timeout).
      e.done_cyc = mt ? (acc + 1 + TO) : (acc + LW * (1 + L));
      fill_q.push_back(e);
    end
  endtask

  // ---------------- driver -----------------------------------------------
  task automatic issue(input bit do_wt, input logic [AW-1:0] wa, input logic [WW-1:0] wd,
                       input bit do_fill, input logic [AW-1:0] fa, input int L,
                       input bit mt, input bit abort);
    bit wt_p, fl_p;
    int n;
    wt_p = do_wt;
    fl_p = do_fill;
    n    = 0;
    @(negedge clk);
    lat = L;
    mute = mt;
    wt_req_valid   = do_wt;
    wt_req_addr    = wa;
    wt_req_data    = wd;
    fill_req_valid = do_fill;
    fill_req_addr  = fa;
    while ((wt_p || fl_p) && n < 100) begin
      #1;
      if (wt_p && fl_p && wt_req_ready) chk("fill_ready_yields_to_write", fill_req_ready, '0);
      if (wt_p && wt_req_ready) begin
        void'(peek(wa));
        ref_mem[wa & ~32'h3] = wd;
        wt_q.push_back({wa, wd});
        wt_p = 1'b0;
      end else if (fl_p && fill_req_ready) begin
        predict_fill(fa, L, mt, abort, cyc + 1);
        fl_p = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
      if (!wt_p) wt_req_valid = 1'b0;
      if (!fl_p) fill_req_valid = 1'b0;
      n++;
    end
    if (n >= 100) begin
      fail_event("request_not_accepted");
      wt_req_valid   = 1'b0;
      fill_req_valid = 1'b0;
    end
    if (!abort) begin
      n = 0;
      #1;
      while (busy && n < 400) begin
        @(negedge clk);
        #1;
        n++;
      end
      if (n >= 400) fail_event("engine_stuck_busy");
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_time_limit");
    $fatal(1, "time limit");
  end

  initial begin
    int            n, s0, kind, L;
    logic [AW-1:0] region, fa, wa;
    rst = 1'b1;
    fill_req_valid = 1'b0; fill_req_addr = '0;
    wt_req_valid = 1'b0; wt_req_addr = '0; wt_req_data = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_busy", busy, '0);
    chk("reset_fill_done", fill_done, '0);
    chk("reset_fill_line", fill_line, '0);
    chk("reset_fill_addr", fill_addr, '0);
    chk("reset_mem_signals", {mem_addr, mem_write_en, mem_read_addr_valid, mem_read_ready}, '0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("idle_fill_ready", fill_req_ready, 1);
    chk("idle_wt_ready", wt_req_ready, 1);
    chk("idle_outputs", {fill_done, fill_err, fill_crit_valid, busy, mem_write_en}, '0);

    // Miss in the middle of a line, latency 3
    issue(0, '0, '0, 1, 32'h0000_1014, 3, 0, 0);
    // Write and fill in the same cycle: fill must observe the new data
    issue(1, 32'h0000_1004, 32'hDEAD_BEEF, 1, 32'h0000_1000, 2, 0, 0);
    chk("write_then_fill_word1", fill_line[63:32], 32'hDEAD_BEEF);
    // Line at the top of the address space: index wraps without carry
    issue(0, '0, '0, 1, 32'hFFFF_FFF6, 1, 0, 0);
    // Memory silent: watchdog expiry, then a normal fill is accepted
    issue(0, '0, '0, 1, 32'h0000_3008, 1, 1, 0);
    issue(0, '0, '0, 1, 32'h0000_300C, 2, 0, 0);

    // Reset during WAIT of the fourth word (word index 3 in fetch order)
    s0 = rd_seen;
    issue(0, '0, '0, 1, 32'h0000_2468, 2, 0, 1);
    n = 0;
    while ((rd_seen - s0) < 4 && n < 200) begin
      @(negedge clk);
      #3;
      n++;
    end
    if (n >= 200) fail_event("abort_read_not_seen");
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("abort_busy", busy, '0);
    chk("abort_fill_line_cleared", fill_line, '0);
    chk("abort_outputs", {fill_done, mem_read_ready, mem_read_addr_valid}, '0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    issue(0, '0, '0, 1, 32'h0000_2468, 3, 0, 0);

    // Randomised mix of writes, fills and write+fill collisions
    for (int it = 0; it < 24; it++) begin
      kind   = $urandom_range(0, 3);
      L      = $urandom_range(1, 4);
      region = ($urandom_range(0, 1) != 0) ? 32'h0000_1000 : 32'hFFFF_F000;
      fa     = region + AW'($urandom_range(0, 511));
      wa     = region + AW'($urandom_range(0, 127) * 4);
      case (kind)
        0:       issue(1, wa, WW'($urandom), 0, '0, L, 0, 0);
        1:       issue(0, '0, '0, 1, fa, L, 0, 0);
        default: issue(1, wa, WW'($urandom), 1, fa, L, 0, 0);
      endcase
    end

    repeat (5) @(negedge clk);
    chk("fill_queue_drained", fill_q.size(), '0);
    chk("read_queue_drained", rd_q.size(), '0);
    chk("write_queue_drained", wt_q.size(), '0);
    chk("crit_queue_drained", crit_q.size(), '0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
